// File: rtl/slice_config_pkg.sv
// Shared types and frame-geometry helpers for the slice configuration loader.
package slice_config_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_COMMIT = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_e;

  // One frame carries both halves of every LUT plus the carry-chain enable bit.
  function automatic int frame_bits(input int cfg_size, input int num_luts);
    return num_luts * 2 * cfg_size + 1;
  endfunction

  function automatic int frame_words(input int fbits, input int word_w);
    return (fbits + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/config_frame_shift.sv
// Shadow frame register: writes one bitstream word at a word index, LSB-first,
// discarding pad bits that fall past the end of the frame.
module config_frame_shift #(
  parameter int FRAME_BITS = 137,
  parameter int WORD_W     = 8,
  parameter int CNT_W      = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  wr_en_i,
  input  logic [CNT_W-1:0]      wr_idx_i,
  input  logic [WORD_W-1:0]     wr_data_i,
  output logic [FRAME_BITS-1:0] frame_o
);

  logic [FRAME_BITS-1:0] frame_q, frame_d;

  // NOTE: frame_d takes frame_q as its default before any branch, so no path leaves it unassigned (no latch).
  always_comb begin
    frame_d = frame_q;
    if (clear_i) begin
      frame_d = '0;
    end else if (wr_en_i) begin
      for (int i = 0; i < FRAME_BITS; i++) begin
        if (wr_idx_i == CNT_W'(i / WORD_W)) begin
          frame_d[i] = wr_data_i[i % WORD_W];
        end
      end
    end
  end

  // NOTE: the frame is reset like any other register because the outputs must read 0 out of reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_q <= '0;
    end else begin
      frame_q <= frame_d;
    end
  end

  assign frame_o = frame_q;

endmodule

// File: rtl/slice_config_loader.sv
// Bitstream-to-frame loader for one logic slice with a one-cycle atomic commit strobe.
// Optional trailing XOR parity word check is enabled by SLICE_CONFIG_LOADER_PARITY_EN.
module slice_config_loader
  import slice_config_pkg::*;
#(
  parameter int S_XX_BASE = 4,
  parameter int CFG_SIZE  = 2**S_XX_BASE + 1,
  parameter int NUM_LUTS  = 4,
  parameter int WORD_W    = 8
) (
  input  logic                  config_clk,
  input  logic                  config_rst,
  input  logic                  start,
  input  logic                  bs_valid,
  input  logic [WORD_W-1:0]     bs_data,
  output logic                  bs_ready,
  output logic [2*CFG_SIZE-1:0] luts_config_out [NUM_LUTS-1:0],
  output logic                  config_use_cc,
  output logic                  config_en,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int FRAME_BITS = frame_bits(CFG_SIZE, NUM_LUTS);
  localparam int WORDS      = frame_words(FRAME_BITS, WORD_W);
  localparam int CNT_W      = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  hs, clear, wr_en, last_word;
  logic [FRAME_BITS-1:0] frame;

  assign hs        = bs_valid & bs_ready;
  assign last_word = (cnt_q == CNT_W'(WORDS - 1));

`ifdef SLICE_CONFIG_LOADER_PARITY_EN
  logic [WORD_W-1:0] par_q, par_d;
  logic              par_match;

  always_comb begin
    par_d = par_q;
    if (clear) begin
      par_d = '0;
    end else if (wr_en) begin
      par_d = par_q ^ bs_data;
    end
  end

  always_ff @(posedge config_clk) begin
    if (config_rst) begin
      par_q <= '0;
    end else begin
      par_q <= par_d;
    end
  end

  assign par_match = (bs_data == par_q);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    err_d   = err_q;
    clear   = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          clear   = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        // A restart outranks a handshake landing in the same cycle.
        if (start) begin
          cnt_d = '0;
          clear = 1'b1;
        end else if (hs) begin
          wr_en = 1'b1;
          if (last_word) begin
            cnt_d = '0;
`ifdef SLICE_CONFIG_LOADER_PARITY_EN
            state_d = ST_CHECK;
`else
            state_d = ST_COMMIT;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`ifdef SLICE_CONFIG_LOADER_PARITY_EN
      ST_CHECK: begin
        if (start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          clear   = 1'b1;
        end else if (hs) begin
          if (par_match) begin
            state_d = ST_COMMIT;
          end else begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
            done_d  = 1'b0;
          end
        end
      end
`endif
      ST_COMMIT: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge config_clk) begin
    if (config_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  config_frame_shift #(
    .FRAME_BITS (FRAME_BITS),
    .WORD_W     (WORD_W),
    .CNT_W      (CNT_W)
  ) u_frame (
    .clk_i     (config_clk),
    .rst_i     (config_rst),
    .clear_i   (clear),
    .wr_en_i   (wr_en),
    .wr_idx_i  (cnt_q),
    .wr_data_i (bs_data),
    .frame_o   (frame)
  );

  for (genvar i = 0; i < NUM_LUTS; i++) begin : g_lut
    assign luts_config_out[i] = frame[2*CFG_SIZE*i +: 2*CFG_SIZE];
  end

  assign config_use_cc = frame[FRAME_BITS-1];
  assign bs_ready      = (state_q == ST_LOAD) || (state_q == ST_CHECK);
  assign busy          = bs_ready || (state_q == ST_COMMIT);
  // COMMIT lasts exactly one cycle, so the strobe cannot repeat back-to-back.
  assign config_en     = (state_q == ST_COMMIT);
  assign done          = done_q;

`ifdef SLICE_CONFIG_LOADER_PARITY_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_slice_config_loader.sv
// Self-checking bench for slice_config_loader: table-driven frames, random frames
// against a bit-mapping reference model, and hand-written restart/reset/parity sequences.
module tb_slice_config_loader;

  localparam int WORD_W     = 8;
  localparam int NUM_LUTS   = 4;
  localparam int CFG_SIZE   = 17;
  localparam int LUT_W      = 2 * CFG_SIZE;
  localparam int FRAME_BITS = NUM_LUTS * LUT_W + 1;
  localparam int WORDS      = (FRAME_BITS + WORD_W - 1) / WORD_W;
`ifdef SLICE_CONFIG_LOADER_PARITY_EN
  localparam int PAR_WORDS  = 1;
`else
  localparam int PAR_WORDS  = 0;
`endif

  typedef logic [WORD_W-1:0] word_t;

  logic              config_clk = 1'b0;
  logic              config_rst;
  logic              start;
  logic              bs_valid;
  word_t             bs_data;
  logic              bs_ready;
  logic [LUT_W-1:0]  luts_config_out [NUM_LUTS-1:0];
  logic              config_use_cc;
  logic              config_en;
  logic              busy;
  logic              done;
  logic              err;

  slice_config_loader dut (
    .config_clk      (config_clk),
    .config_rst      (config_rst),
    .start           (start),
    .bs_valid        (bs_valid),
    .bs_data         (bs_data),
    .bs_ready        (bs_ready),
    .luts_config_out (luts_config_out),
    .config_use_cc   (config_use_cc),
    .config_en       (config_en),
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  always #5 config_clk = ~config_clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int en_count    = 0;
  int last_edge   = 0;
  logic prev_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  always @(posedge config_clk) cyc++;

  always @(negedge config_clk) begin
    if (config_en) begin
      en_count++;
      check("config_en_not_back_to_back", prev_en, 1'b0);
    end
    prev_en = config_en;
  end

  // Reference: frame bit k is bit (k mod WORD_W) of word (k div WORD_W).
  function automatic logic [FRAME_BITS-1:0] model_frame(input word_t ws[$]);
    logic [FRAME_BITS-1:0] f;
    f = '0;
    for (int k = 0; k < FRAME_BITS; k++) begin
      word_t w;
      w    = ws[k / WORD_W];
      f[k] = w[k % WORD_W];
    end
    return f;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge config_clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input word_t w, input int gap_pct);
    int budget;
    budget = 50;
    if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
      bs_valid = 1'b0;
      bs_data  = word_t'($urandom);
      @(posedge config_clk); #1;
    end
    bs_valid = 1'b1;
    bs_data  = w;
    forever begin
      @(negedge config_clk);
      if (bs_ready) break;
      budget--;
      if (budget == 0) begin
        check("bs_ready_timeout", 1'b0, 1'b1);
        break;
      end
    end
    @(posedge config_clk); #1;
    last_edge = cyc;
    bs_valid  = 1'b0;
  endtask

  task automatic run_frame(input string name, input word_t ws[$], input int gap,
                           input bit corrupt, input bit do_start, input bit commit_start);
    int                    en_before, start_edge, pct;
    word_t                 par;
    logic [FRAME_BITS-1:0] f;
    en_before  = en_count;
    start_edge = cyc;
    if (do_start) begin
      pulse_start();
      start_edge = cyc;
    end
    par = '0;
    for (int i = 0; i < ws.size(); i++) begin
      pct = (gap == 1) ? ((i % 2 == 1) ? 100 : 0) : ((gap == 2) ? 40 : 0);
      send_word(ws[i], pct);
      par ^= ws[i];
    end
`ifdef SLICE_CONFIG_LOADER_PARITY_EN
    if (corrupt) par ^= 8'h10;
    send_word(par, 0);
`endif
    if (do_start && gap == 0)
      check({name, " handshake_edges"}, 64'(last_edge - start_edge), 64'(ws.size() + PAR_WORDS));
    check({name, " config_en_after_last"}, config_en, !corrupt);
    check({name, " done_not_yet"}, done, 1'b0);
    check({name, " err_on_entry"}, err, corrupt);
    if (commit_start) start = 1'b1;
    @(posedge config_clk); #1;
    start = 1'b0;
    check({name, " config_en_dropped"}, config_en, 1'b0);
    check({name, " done"}, done, !corrupt);
    check({name, " busy_idle"}, busy, 1'b0);
    check({name, " ready_low"}, bs_ready, 1'b0);
    @(negedge config_clk);
    check({name, " config_en_count"}, 64'(en_count - en_before), corrupt ? 64'd0 : 64'd1);
    if (!corrupt) begin
      f = model_frame(ws);
      for (int i = 0; i < NUM_LUTS; i++)
        check($sformatf("%s lut%0d", name, i), luts_config_out[i], f[i*LUT_W +: LUT_W]);
      check({name, " use_cc"}, config_use_cc, f[FRAME_BITS-1]);
    end
  endtask

  task automatic check_all_zero(input string name);
    for (int i = 0; i < NUM_LUTS; i++)
      check($sformatf("%s lut%0d", name, i), luts_config_out[i], '0);
    check({name, " use_cc"}, config_use_cc, 1'b0);
    check({name, " config_en"}, config_en, 1'b0);
    check({name, " bs_ready"}, bs_ready, 1'b0);
    check({name, " busy"}, busy, 1'b0);
    check({name, " done"}, done, 1'b0);
    check({name, " err"}, err, 1'b0);
  endtask

  typedef struct {
    string            name;
    int               pattern;   // 0 ramp 0x00.., 1 all 0xA5, 2 random
    int               gap;       // 0 back-to-back, 1 valid toggling, 2 random gaps
    bit               has_exp;
    logic [LUT_W-1:0] exp_lut0;
    logic             exp_cc;
  } vec_t;

  vec_t vecs [7];

  function automatic void build_words(input int pattern, output word_t ws[$]);
    ws = {};
    for (int i = 0; i < WORDS; i++) begin
      case (pattern)
        0:       ws.push_back(word_t'(i));
        1:       ws.push_back(8'hA5);
        default: ws.push_back(word_t'($urandom));
      endcase
    end
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    word_t ws[$];

    vecs[0] = '{"ramp",        0, 0, 1'b1, 34'h003020100, 1'b1};
    vecs[1] = '{"ramp_toggle", 0, 1, 1'b1, 34'h003020100, 1'b1};
    vecs[2] = '{"a5",          1, 0, 1'b1, 34'h1A5A5A5A5, 1'b1};
    vecs[3] = '{"rand0",       2, 0, 1'b0, '0, 1'b0};
    vecs[4] = '{"rand1",       2, 2, 1'b0, '0, 1'b0};
    vecs[5] = '{"rand2",       2, 2, 1'b0, '0, 1'b0};
    vecs[6] = '{"rand3",       2, 1, 1'b0, '0, 1'b0};

    config_rst = 1'b1;
    start      = 1'b0;
    bs_valid   = 1'b1;
    bs_data    = 8'h5A;
    repeat (3) @(posedge config_clk);
    #1;
    check_all_zero("reset");
    config_rst = 1'b0;
    bs_valid   = 1'b0;
    @(posedge config_clk); #1;

    for (int v = 0; v < 7; v++) begin
      build_words(vecs[v].pattern, ws);
      run_frame(vecs[v].name, ws, vecs[v].gap, 1'b0, 1'b1, 1'b0);
      if (vecs[v].has_exp) begin
        check({vecs[v].name, " table_lut0"}, luts_config_out[0], vecs[v].exp_lut0);
        check({vecs[v].name, " table_cc"}, config_use_cc, vecs[v].exp_cc);
      end
    end

    // Restart after 5 words; the handshake coincident with start must be dropped.
    pulse_start();
    build_words(2, ws);
    for (int i = 0; i < 5; i++) send_word(ws[i], 0);
    start    = 1'b1;
    bs_valid = 1'b1;
    bs_data  = 8'hFF;
    @(posedge config_clk); #1;
    start    = 1'b0;
    bs_valid = 1'b0;
    build_words(1, ws);
    run_frame("restart", ws, 0, 1'b0, 1'b0, 1'b0);
    check("restart table_lut0", luts_config_out[0], 34'h1A5A5A5A5);

    // start during COMMIT is ignored: the frame still lands in DONE.
    build_words(2, ws);
    run_frame("commit_start", ws, 0, 1'b0, 1'b1, 1'b1);

    // Reset after word 10 abandons the frame.
    begin
      int en_before;
      en_before = en_count;
      pulse_start();
      build_words(2, ws);
      for (int i = 0; i < 10; i++) send_word(ws[i], 0);
      config_rst = 1'b1;
      @(posedge config_clk); #1;
      config_rst = 1'b0;
      check_all_zero("midload_reset");
      bs_valid = 1'b1;
      bs_data  = 8'h3C;
      repeat (2) @(posedge config_clk);
      #1;
      check("midload_reset idle_no_ready", bs_ready, 1'b0);
      check("midload_reset idle_not_busy", busy, 1'b0);
      bs_valid = 1'b0;
      @(negedge config_clk);
      check("midload_reset no_config_en", 64'(en_count - en_before), 64'd0);
    end

`ifdef SLICE_CONFIG_LOADER_PARITY_EN
    build_words(2, ws);
    run_frame("parity_bad", ws, 0, 1'b1, 1'b1, 1'b0);
    pulse_start();
    check("parity_bad err_cleared", err, 1'b0);
    check("parity_bad restart_busy", busy, 1'b1);
    check("parity_bad restart_done", done, 1'b0);
    build_words(2, ws);
    run_frame("parity_recover", ws, 2, 1'b0, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
